// File: rtl/uart_file_loader_if.sv
// Byte streams to/from the system UART and the word write port toward memory.
// master = loader side, slave = UART/memory side.
interface uart_file_loader_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ready;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready,
    input  rx_data, rx_valid,
    output rx_ready,
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready,
    output rx_data, rx_valid,
    input  rx_ready,
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready
  );
endinterface

// File: rtl/uart_file_loader.sv
// Receives a file over the UART byte link and writes it to memory as
// little-endian 32-bit words starting at BASE_ADDR.
//
// state    | meaning
// S_IDLE   | waiting for start_i
// S_SEND   | offering the 0x02 "send file" command to the transmitter
// S_SIZE   | collecting the 4-byte little-endian file size
// S_DATA   | packing payload bytes into the word buffer
// S_WRITE  | holding a word write until mem_ready
// S_DONE   | one cycle before done_o rises
// S_ERROR  | one cycle before error_o rises (oversize file)
module uart_file_loader #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       MAX_BYTES = 65536
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o,
  output logic [31:0]         file_size_o,
  uart_file_loader_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_SIZE, S_DATA, S_WRITE, S_DONE, S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        size_cnt_q, size_cnt_d;
  logic [31:0]       file_size_q, file_size_d;
  logic [31:0]       rem_q, rem_d;
  logic [31:0]       wbuf_q, wbuf_d;
  logic [3:0]        strb_q, strb_d;
  logic [1:0]        lane_q, lane_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [31:0]       size_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      size_cnt_q  <= '0;
      file_size_q <= '0;
      rem_q       <= '0;
      wbuf_q      <= '0;
      strb_q      <= '0;
      lane_q      <= '0;
      addr_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_cnt_q  <= size_cnt_d;
      file_size_q <= file_size_d;
      rem_q       <= rem_d;
      wbuf_q      <= wbuf_d;
      strb_q      <= strb_d;
      lane_q      <= lane_d;
      addr_q      <= addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    size_cnt_d  = size_cnt_q;
    file_size_d = file_size_q;
    rem_d       = rem_q;
    wbuf_d      = wbuf_q;
    strb_d      = strb_q;
    lane_d      = lane_q;
    addr_d      = addr_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    size_full   = {bus.rx_data, file_size_q[23:0]};

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d     = S_SEND;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
          addr_d      = BASE_ADDR;
          size_cnt_d  = '0;
          file_size_d = '0;
          lane_d      = '0;
          wbuf_d      = '0;
          strb_d      = '0;
        end
      end
      S_SEND: begin
        if (bus.tx_ready) state_d = S_SIZE;
      end
      S_SIZE: begin
        if (bus.rx_valid) begin
          file_size_d[{size_cnt_q, 3'b000} +: 8] = bus.rx_data;
          size_cnt_d = size_cnt_q + 2'd1;
          if (size_cnt_q == 2'd3) begin
            rem_d = size_full;
            if (size_full == 32'd0)            state_d = S_DONE;
            else if (size_full > MAX_BYTES)    state_d = S_ERROR;
            else                               state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (bus.rx_valid) begin
          wbuf_d[{lane_q, 3'b000} +: 8] = bus.rx_data;
          strb_d[lane_q] = 1'b1;
          lane_d = lane_q + 2'd1;
          rem_d  = rem_q - 32'd1;
          if (lane_q == 2'd3 || rem_q == 32'd1) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus.mem_ready) begin
          // Clearing the buffer keeps unwritten lanes of a final partial word at zero.
          addr_d  = addr_q + ADDR_W'(4);
          lane_d  = '0;
          wbuf_d  = '0;
          strb_d  = '0;
          state_d = (rem_q != 32'd0) ? S_DATA : S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_ERROR: begin
        busy_d  = 1'b0;
        error_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Valid/ready outputs depend only on registered state, never on the peer's handshake input.
  assign bus.tx_valid  = (state_q == S_SEND);
  assign bus.tx_data   = (state_q == S_SEND) ? 8'h02 : 8'h00;
  assign bus.rx_ready  = (state_q == S_SIZE) || (state_q == S_DATA);
  assign bus.mem_valid = (state_q == S_WRITE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wbuf_q;
  assign bus.mem_wstrb = strb_q;

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign file_size_o = file_size_q;

endmodule

// File: doc/uart_file_loader.md
Name: uart_file_loader

Overview:
- Device-side engine for the UART file-transfer protocol.
- On request, sends the "send file" command byte (0x02) to the host, then receives a 4-byte little-endian file size and the payload bytes.
- Packs the payload into 32-bit little-endian words and writes them to a memory port starting at BASE_ADDR. It is the receiving end of the host's send-file task.
- Sits between the system UART byte interface and main memory / the DDR write path, so a program or data image loads without CPU involvement.

Parameters:
- ADDR_W, 32, memory address width (byte address).
- BASE_ADDR, 0, byte address of the first payload word; must be 4-byte aligned.
- MAX_BYTES, 65536, largest accepted file size in bytes.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a transfer when idle.
- busy  out  1  high from start acceptance until done/error.
- done  out  1  high after a successful transfer; held until the next accepted start.
- error  out  1  high after an oversize rejection; held until the next accepted start.
- file_size  out  32  size received from the host; valid once the SIZE state completes.
- tx_data  out  8  byte to the UART transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts the byte on a cycle where tx_valid and tx_ready are both high.
- rx_data  in  8  byte from the UART receiver.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  byte consumed on a cycle where rx_valid and rx_ready are both high.
- mem_valid  out  1  write request.
- mem_addr  out  ADDR_W  word-aligned byte address.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  byte enables.
- mem_ready  in  1  write accepted on a cycle where mem_valid and mem_ready are both high.

Behaviour:
- Reset values:
  - state IDLE; all outputs 0; file_size 0.
  - Internal byte counter, word buffer and lane index cleared.
- IDLE:
  - start=1 → SEND_REQ; busy=1, done=0, error=0, address=BASE_ADDR.
  - start is ignored in every other state.
- SEND_REQ:
  - tx_valid=1, tx_data=0x02, both held stable until tx_ready.
  - On handshake → SIZE.
- SIZE:
  - rx_ready=1; four accepted bytes fill file_size[7:0], [15:8], [23:16], [31:24] in that order.
  - After the 4th byte:
    - size==0 → DONE.
    - size>MAX_BYTES → ERROR.
    - Otherwise → DATA.
- DATA:
  - rx_ready=1; each accepted byte goes into word lane k (k=0..3, bits 8k+7:8k), k increments, remaining count decrements.
  - When k wraps from 3, or on the last byte of the file → WRITE.
- WRITE:
  - rx_ready=0; mem_valid=1; mem_addr, mem_wdata and mem_wstrb held stable until mem_ready.
  - mem_wstrb = 4'b1111 for a full word. For the final partial word: 4'b0001, 0011 or 0111 for 1, 2 or 3 bytes; unwritten lanes are 0.
  - On handshake: mem_addr += 4, k=0. Remaining>0 → DATA, else → DONE.
- DONE: busy=0, done=1 → IDLE (done stays high until the next accepted start).
- ERROR:
  - busy=0, error=1 → IDLE.
  - Payload is not drained; the host is expected to abort.
- Handshake rules:
  - rx_ready is never high outside SIZE and DATA.
  - tx_valid is never high outside SEND_REQ.
  - mem_valid is never high outside WRITE.
  - No combinational path from rx_valid/tx_ready/mem_ready to the corresponding valid outputs.
  - Bytes arriving while rx_ready=0 are left to the UART FIFO.
- Latency:
  - start to tx_valid: 1 cycle.
  - Last byte of a word accepted to mem_valid: 1 cycle.
  - Final write handshake to done: 2 cycles (via DONE).
- Counters: 32-bit remaining-byte counter. mem_addr wraps modulo 2^ADDR_W with no error; the MAX_BYTES check prevents this in a valid configuration.
- Reset mid-transfer: asynchronous return to reset values on rst_n=0; any partial word is discarded.

Test Plan:
- BASE_ADDR=0x100; start; host returns size 8, bytes 11..18 → tx 0x02 once; mem writes (0x100, 0x14131211, 1111) and (0x104, 0x18171615, 1111); done=1, file_size=8.
- Size 6, bytes AA BB CC DD EE FF → second write (0x104, 0x0000FFEE, 0011); done=1.
- Size 0 → no mem_valid; done=1 two cycles after the 4th size byte.
- MAX_BYTES=16, size 17 → error=1, done=0, no mem_valid, rx_ready low afterwards.
- mem_ready held low 10 cycles during the first write → rx_ready=0 and mem_* stable throughout; no byte lost; the remaining sequence matches the first scenario.
- rst_n pulsed low after 5 payload bytes → all outputs 0 immediately. A new start then behaves as the first scenario, and a second start pulse during the transfer has no effect.
